pts_host_loader: RTL
====================

// Module: pts_host_loader
// PURPOSE
//  Host-side programming front end for the 32-channel PTS sequencer. Parses a byte
//  command stream from the host link (UART/USB receiver output) and emits the
//  set-index, set-code and trigger strobes that load and step the sequencer table.
//  Reads back the current index and code on request through a byte TX handshake.
//  Sits between the host byte link and ptsController_32ch; one instance per sequencer.
// PARAMETERS
//  PULSE_LEN  4         cycles each strobe (oSET_INDEX_FLAG/oSET_CODE_FLAG/oTrigger) stays high, >=2
//  TIMEOUT    100000    idle cycles inside a frame before the frame is abandoned
//  AUTO_INC   0         1: issue one oTrigger pulse after every completed code write
// PORTS
//  iClk             in   1   system clock
//  iRst             in   1   synchronous reset, active high
//  iRxData          in   8   received host byte
//  iRxValid         in   1   1-cycle strobe, iRxData valid; no backpressure
//  oTxData          out  8   readback byte
//  oTxValid         out  1   readback byte valid; held until accepted
//  iTxReady         in   1   TX sink accepts byte when oTxValid&&iTxReady
//  oSET_INDEX_FLAG  out  1   index load strobe to sequencer
//  oSET_INDEX       out  8   index value
//  oSET_CODE_FLAG   out  1   code write strobe to sequencer
//  oSET_CODE        out  32  code value
//  oTrigger         out  1   step strobe to sequencer
//  iCurIndex        in   8   sequencer current index (debug_index)
//  iCurCode         in   32  sequencer current code (debug_current_storge)
//  oBusy            out  1   high whenever FSM not in IDLE
//  oErr             out  1   1-cycle pulse on any protocol error
//  oErrCount        out  8   saturating error count (stops at 255)
// BEHAVIOUR
//  Clocking: one clock (iClk); reset synchronous and active-high (iRst), all state cleared on it.
//  Reset: all outputs 0, FSM=IDLE, oErrCount=0; reset mid-strobe drops strobe next edge.
//  Frames (opcode byte then payload): 0x49 'I'+1B index; 0x43 'C'+4B code MSB first;
//   0x54 'T' none; 0x52 'R' none -> readback.
//  States: IDLE, GET_IDX, GET_CODE(byte cnt 0..3), SETUP, PULSE, HOLD, INC_SETUP,
//   INC_PULSE, TX(byte cnt 0..4).
//  IDLE: unknown opcode -> oErr, stay IDLE. 'T' -> PULSE directly (no payload).
//  Payload complete -> SETUP: oSET_INDEX/oSET_CODE updated this cycle, flags still 0.
//  PULSE: selected flag high exactly PULSE_LEN cycles; data stable throughout.
//  HOLD: 1 cycle, flag low, data unchanged (sequencer samples on falling edge).
//  After 'C' HOLD: AUTO_INC=1 -> INC_SETUP(1 cycle) -> INC_PULSE (oTrigger PULSE_LEN
//   cycles) -> IDLE; else IDLE. Strobes never overlap; at most one high at a time.
//  oSET_INDEX/oSET_CODE keep last value in IDLE (no return to 0).
//  Latency: last payload byte at cycle n -> flag high n+2..n+1+PULSE_LEN.
//  'R': capture iCurIndex,iCurCode in IDLE cycle after opcode; send 5 bytes:
//   index, code[31:24],[23:16],[15:8],[7:0]. oTxValid/oTxData stable until iTxReady.
//  Bytes arriving in SETUP/PULSE/HOLD/INC_*/TX: dropped, oErr pulse, FSM unaffected.
//  Timeout: in GET_IDX/GET_CODE, TIMEOUT cycles with no iRxValid -> oErr, IDLE; counter
//   restarts on every accepted byte. TX never times out.
//  oErrCount increments on each oErr, saturates at 8'hFF.
//  oBusy = (state != IDLE).
// STRUCTURE
//  pts_pkg: opcode localparams (OP_IDX/OP_CODE/OP_TRIG/OP_READ), FSM state encoding,
//   readback frame length (5).
//  Sub-module pts_strobe_gen: PULSE_LEN down-counter producing one clean pulse on
//   start; instantiated once, shared by all three strobes via select mux.
// TESTING
//  Reset: iRst 3 cycles -> all outputs 0, oErrCount=0, oBusy=0.
//  Rx 49,07 -> oSET_INDEX=8'h07 one cycle before oSET_INDEX_FLAG, flag high 4 cycles.
//  Rx 43,DE,AD,BE,EF, AUTO_INC=1 -> oSET_CODE=32'hDEADBEEF, code flag 4 cyc, HOLD, oTrigger 4 cyc.
//  iCurIndex=8'h12,iCurCode=32'h01020304, Rx 52, iTxReady toggled -> TX 12,01,02,03,04 in order.
//  Rx 43,11 then silence TIMEOUT cycles -> oErr pulse, oErrCount=1, no strobe, IDLE.
//  Rx 58 (bad opcode) x300 -> oErrCount=255 saturated; byte during PULSE -> dropped, oErr.

Source files
------------

// File: rtl/pts_pkg.sv
// Shared constants for the PTS host loader: opcodes, FSM encoding, readback framing.
// Helper picks one byte out of the captured readback frame.
package pts_pkg;

    localparam logic [7:0] OP_IDX  = 8'h49;
    localparam logic [7:0] OP_CODE = 8'h43;
    localparam logic [7:0] OP_TRIG = 8'h54;
    localparam logic [7:0] OP_READ = 8'h52;

    localparam int RB_LEN = 5;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GET_IDX   = 4'd1;
    localparam logic [3:0] S_GET_CODE  = 4'd2;
    localparam logic [3:0] S_SETUP     = 4'd3;
    localparam logic [3:0] S_PULSE     = 4'd4;
    localparam logic [3:0] S_HOLD      = 4'd5;
    localparam logic [3:0] S_INC_SETUP = 4'd6;
    localparam logic [3:0] S_INC_PULSE = 4'd7;
    localparam logic [3:0] S_TX        = 4'd8;

    typedef enum logic [1:0] {
        SEL_IDX  = 2'd0,
        SEL_CODE = 2'd1,
        SEL_TRIG = 2'd2
    } strobeSel_t;

    // Frame is {index, code[31:0]}; byte 0 goes out first.
    function automatic logic [7:0] rbByte(
        input logic [39:0] frame,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = frame[39:32];
            3'd1:    b = frame[31:24];
            3'd2:    b = frame[23:16];
            3'd3:    b = frame[15:8];
            default: b = frame[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pts_strobe_gen.sv
// Single shared strobe timer: one clean pulse of PULSE_LEN cycles per start.
// oDone marks the final high cycle so the FSM can leave on the same edge.
module pts_strobe_gen #(
    parameter int PULSE_LEN = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iStart,
    output logic oPulse,
    output logic oDone
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oPulse <= 1'b0;
            cnt    <= '0;
        end else if (iStart) begin
            oPulse <= 1'b1;
            cnt    <= CW'(PULSE_LEN - 1);
        end else if (oPulse) begin
            if (cnt == '0) begin
                oPulse <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign oDone = oPulse && (cnt == '0);

endmodule

// File: rtl/pts_host_loader.sv
// Host byte-stream front end for the 32-channel PTS sequencer: parses
// index/code/trigger/readback frames and drives the sequencer load strobes.
module pts_host_loader
    import pts_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 100000,
    parameter int AUTO_INC  = 0
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady,
    output logic        oSET_INDEX_FLAG,
    output logic [7:0]  oSET_INDEX,
    output logic        oSET_CODE_FLAG,
    output logic [31:0] oSET_CODE,
    output logic        oTrigger,
    input  logic [7:0]  iCurIndex,
    input  logic [31:0] iCurCode,
    output logic        oBusy,
    output logic        oErr,
    output logic [7:0]  oErrCount
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]    state;
    logic [1:0]    byteCnt;
    logic [23:0]   codeAcc;
    logic [TW-1:0] toCnt;
    logic [39:0]   rbFrame;
    logic [2:0]    txCnt;
    strobeSel_t    sel;

    logic pulse;
    logic pulseDone;
    logic strobeStart;
    logic inGet;
    logic knownOp;
    logic timeoutHit;
    logic dropByte;
    logic errEvent;

    assign inGet = (state == S_GET_IDX) || (state == S_GET_CODE);

    assign knownOp = (iRxData == OP_IDX) || (iRxData == OP_CODE) ||
                     (iRxData == OP_TRIG) || (iRxData == OP_READ);

    assign timeoutHit = inGet && !iRxValid &&
                        (toCnt == TW'(TIMEOUT - 1));

    // Anything outside IDLE and the payload states cannot take a byte.
    assign dropByte = iRxValid && (state != S_IDLE) && !inGet;

    assign errEvent = (iRxValid && (state == S_IDLE) && !knownOp) ||
                      dropByte || timeoutHit;

    assign strobeStart = (state == S_SETUP) || (state == S_INC_SETUP) ||
                         ((state == S_IDLE) && iRxValid &&
                          (iRxData == OP_TRIG));

    pts_strobe_gen #(
        .PULSE_LEN(PULSE_LEN)
    ) uStrobe (
        .iClk  (iClk),
        .iRst  (iRst),
        .iStart(strobeStart),
        .oPulse(pulse),
        .oDone (pulseDone)
    );

    assign oSET_INDEX_FLAG = pulse && (sel == SEL_IDX);
    assign oSET_CODE_FLAG  = pulse && (sel == SEL_CODE);
    assign oTrigger        = pulse && (sel == SEL_TRIG);

    assign oBusy    = (state != S_IDLE);
    assign oTxValid = (state == S_TX);
    assign oTxData  = oTxValid ? rbByte(rbFrame, txCnt) : 8'h00;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oErr      <= 1'b0;
            oErrCount <= 8'h00;
        end else begin
            oErr <= errEvent;
            if (errEvent && (oErrCount != 8'hFF)) begin
                oErrCount <= oErrCount + 8'd1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= S_IDLE;
            byteCnt    <= '0;
            codeAcc    <= '0;
            toCnt      <= '0;
            rbFrame    <= '0;
            txCnt      <= '0;
            sel        <= SEL_IDX;
            oSET_INDEX <= '0;
            oSET_CODE  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    toCnt <= '0;
                    if (iRxValid) begin
                        unique case (1'b1)
                            (iRxData == OP_IDX): begin
                                state <= S_GET_IDX;
                            end
                            (iRxData == OP_CODE): begin
                                state   <= S_GET_CODE;
                                byteCnt <= '0;
                            end
                            (iRxData == OP_TRIG): begin
                                state <= S_PULSE;
                                sel   <= SEL_TRIG;
                            end
                            (iRxData == OP_READ): begin
                                state   <= S_TX;
                                rbFrame <= {iCurIndex, iCurCode};
                                txCnt   <= '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_GET_IDX: begin
                    if (iRxValid) begin
                        oSET_INDEX <= iRxData;
                        sel        <= SEL_IDX;
                        state      <= S_SETUP;
                    end else if (timeoutHit) begin
                        state <= S_IDLE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                S_GET_CODE: begin
                    if (iRxValid) begin
                        toCnt <= '0;
                        if (byteCnt == 2'd3) begin
                            oSET_CODE <= {codeAcc, iRxData};
                            sel       <= SEL_CODE;
                            state     <= S_SETUP;
                        end else begin
                            codeAcc <= {codeAcc[15:0], iRxData};
                            byteCnt <= byteCnt + 1'b1;
                        end
                    end else if (timeoutHit) begin
                        state <= S_IDLE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    state <= S_PULSE;
                end
                S_PULSE: begin
                    if (pulseDone) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if ((AUTO_INC != 0) && (sel == SEL_CODE)) begin
                        sel   <= SEL_TRIG;
                        state <= S_INC_SETUP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_INC_SETUP: begin
                    state <= S_INC_PULSE;
                end
                S_INC_PULSE: begin
                    if (pulseDone) begin
                        state <= S_IDLE;
                    end
                end
                S_TX: begin
                    if (iTxReady) begin
                        if (txCnt == 3'(RB_LEN - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            txCnt <= txCnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
